text_stream_writer: RTL and testbench

- Write-side initiator for the text-mode video memory write port.
- Consumes a byte stream through a valid/ready handshake: printable characters, cursor controls, clear-screen and an absolute-positioning escape.
- Converts each accepted byte into single-cycle cell writes (`write`, `xtextwrite`, `ytextwrite`, `value`) at a tracked cursor.
- Sits between the host/UART byte source and the video memory.

---
 rtl/text_stream_writer.sv | 151 +++++++++++++++
 tb/tb_text_stream_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_stream_writer.sv
// Byte-stream to text-cell writer: prints characters, handles cursor controls and the
// 0x1F row/col escape. Define TEXT_STREAM_WRITER_CLEAR_EN to build the FF clear-screen sweep.
module text_stream_writer #(
    parameter int COLS   = 40,
    parameter int ROWS   = 25,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 5,
    parameter int ATTR_W = 24,
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic [ATTR_W-1:0] attr,
    output logic              write,
    output logic [COL_W-1:0]  xtextwrite,
    output logic [ROW_W-1:0]  ytextwrite,
    output logic [ATTR_W-1:0] value,
    output logic [COL_W-1:0]  cursor_x,
    output logic [ROW_W-1:0]  cursor_y,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ESC_ROW, ESC_COL, CLEAR} state_t;

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [7:0]       COL_MAX_B = 8'(COLS - 1);
    localparam logic [7:0]       ROW_MAX_B = 8'(ROWS - 1);

    state_t              state_q;
    logic [COL_W-1:0]    cursor_x_q;
    logic [ROW_W-1:0]    cursor_y_q;
    logic [ROW_W-1:0]    esc_row_q;
    logic                write_q;
    logic [COL_W-1:0]    wx_q;
    logic [ROW_W-1:0]    wy_q;
    logic [ATTR_W-1:0]   value_q;

    logic [7:0]          arg_off_d;
    logic [ROW_W-1:0]    row_arg_d;
    logic [COL_W-1:0]    col_arg_d;
    logic [ROW_W-1:0]    cy_inc_d;
    logic                unused_attr_lo;

    assign unused_attr_lo = ^attr[CHAR_W-1:0];

    // Escape arguments are offset by 0x40 and saturate at the screen edge.
    assign arg_off_d = in_byte - 8'h40;
    assign row_arg_d = (in_byte < 8'h40)       ? '0 :
                       (arg_off_d > ROW_MAX_B) ? ROW_MAX : arg_off_d[ROW_W-1:0];
    assign col_arg_d = (in_byte < 8'h40)       ? '0 :
                       (arg_off_d > COL_MAX_B) ? COL_MAX : arg_off_d[COL_W-1:0];
    assign cy_inc_d  = (cursor_y_q == ROW_MAX) ? '0 : cursor_y_q + ROW_W'(1);

`ifdef TEXT_STREAM_WRITER_CLEAR_EN
    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(8'h20);
    assign in_ready = (state_q != CLEAR);
    assign busy     = (state_q == CLEAR);
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            esc_row_q  <= '0;
            write_q    <= 1'b0;
            wx_q       <= '0;
            wy_q       <= '0;
            value_q    <= '0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    if (in_byte >= 8'h20) begin
                        write_q <= 1'b1;
                        wx_q    <= cursor_x_q;
                        wy_q    <= cursor_y_q;
                        value_q <= {attr[ATTR_W-1:CHAR_W], CHAR_W'(in_byte)};
                        if (cursor_x_q == COL_MAX) begin
                            cursor_x_q <= '0;
                            cursor_y_q <= cy_inc_d;
                        end else begin
                            cursor_x_q <= cursor_x_q + COL_W'(1);
                        end
                    end else begin
                        case (in_byte)
                            8'h08: if (cursor_x_q != '0) cursor_x_q <= cursor_x_q - COL_W'(1);
                            8'h0A: cursor_y_q <= cy_inc_d;
                            8'h0D: cursor_x_q <= '0;
                            8'h1F: state_q <= ESC_ROW;
`ifdef TEXT_STREAM_WRITER_CLEAR_EN
                            // First blank cell goes out with the FF itself so write stays
                            // high exactly while in_ready is low.
                            8'h0C: begin
                                state_q <= CLEAR;
                                write_q <= 1'b1;
                                wx_q    <= '0;
                                wy_q    <= '0;
                                value_q <= {attr[ATTR_W-1:CHAR_W], BLANK};
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ESC_ROW: if (in_valid) begin
                    esc_row_q <= row_arg_d;
                    state_q   <= ESC_COL;
                end
                ESC_COL: if (in_valid) begin
                    cursor_x_q <= col_arg_d;
                    cursor_y_q <= esc_row_q;
                    state_q    <= IDLE;
                end
`ifdef TEXT_STREAM_WRITER_CLEAR_EN
                // The write address registers double as the sweep counter.
                CLEAR: begin
                    if (wx_q == COL_MAX && wy_q == ROW_MAX) begin
                        state_q    <= IDLE;
                        cursor_x_q <= '0;
                        cursor_y_q <= '0;
                    end else begin
                        write_q <= 1'b1;
                        value_q <= {attr[ATTR_W-1:CHAR_W], BLANK};
                        if (wx_q == COL_MAX) begin
                            wx_q <= '0;
                            wy_q <= wy_q + ROW_W'(1);
                        end else begin
                            wx_q <= wx_q + COL_W'(1);
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign write      = write_q;
    assign xtextwrite = wx_q;
    assign ytextwrite = wy_q;
    assign value      = value_q;
    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
endmodule

// File: tb/tb_text_stream_writer.sv
// Directed plus randomized bench for text_stream_writer with a screen-level reference model.
module tb_text_stream_writer;
    localparam int COLS = 40;
    localparam int ROWS = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic [23:0] attr = 24'h0;
    logic        in_ready, write, busy;
    logic [5:0]  xtextwrite, cursor_x;
    logic [4:0]  ytextwrite, cursor_y;
    logic [23:0] value;

    text_stream_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .attr(attr), .write(write), .xtextwrite(xtextwrite),
        .ytextwrite(ytextwrite), .value(value), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, fails = 0;
    int ex = 0, ey = 0, mode = 0, erow = 0;
    bit exp_wr = 1'b0;
    int exp_x = 0, exp_y = 0;
    logic [23:0] exp_v = 24'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    // Screen model: cursor as a linear cell index, escape as a small mode counter.
    task automatic model_step(input logic [7:0] b);
        int idx;
        exp_wr = 1'b0;
        if (mode == 1) begin
            erow = clampi(int'(b) - 64, ROWS - 1);
            mode = 2;
        end else if (mode == 2) begin
            ex = clampi(int'(b) - 64, COLS - 1);
            ey = erow;
            mode = 0;
        end else if (b >= 8'h20) begin
            exp_wr = 1'b1;
            exp_x = ex; exp_y = ey;
            exp_v = {attr[23:8], b};
            idx = (ey * COLS + ex + 1) % (COLS * ROWS);
            ex = idx % COLS;
            ey = idx / COLS;
        end else begin
            case (b)
                8'h08: if (ex > 0) ex = ex - 1;
                8'h0A: ey = (ey + 1) % ROWS;
                8'h0D: ex = 0;
                8'h1F: mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk($sformatf("%s.write", ctx), write, exp_wr);
        if (exp_wr) begin
            chk($sformatf("%s.x", ctx), xtextwrite, exp_x);
            chk($sformatf("%s.y", ctx), ytextwrite, exp_y);
            chk($sformatf("%s.value", ctx), value, exp_v);
        end
        chk($sformatf("%s.cursor_x", ctx), cursor_x, ex);
        chk($sformatf("%s.cursor_y", ctx), cursor_y, ey);
        chk($sformatf("%s.in_ready", ctx), in_ready, 1);
        chk($sformatf("%s.busy", ctx), busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input string ctx);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        model_step(b);
        #1;
        in_valid = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        exp_wr = 1'b0;
        #1;
        check_outputs("idle");
    endtask

`ifdef TEXT_STREAM_WRITER_CLEAR_EN
    // Starts a clear with 'hold' queued behind it; checks n cells of the sweep.
    task automatic clear_sweep(input int n, input logic [7:0] hold);
        in_valid = 1'b1;
        in_byte  = 8'h0C;
        @(posedge clk);
        #1;
        in_byte  = hold;
        in_valid = (hold != 8'h00);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("clr%0d.write", k), write, 1);
            chk($sformatf("clr%0d.x", k), xtextwrite, k % COLS);
            chk($sformatf("clr%0d.y", k), ytextwrite, k / COLS);
            chk($sformatf("clr%0d.value", k), value, {attr[23:8], 8'h20});
            chk($sformatf("clr%0d.in_ready", k), in_ready, 0);
            chk($sformatf("clr%0d.busy", k), busy, 1);
            if (k == n - 1) break;
            attr = 24'($urandom);
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        logic [7:0] b;
        int r;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_wr = 1'b0;
        check_outputs("reset");
        chk("reset.x", xtextwrite, 0);
        chk("reset.y", ytextwrite, 0);
        chk("reset.value", value, 0);
        reset = 1'b0;
        attr = 24'hA5C300;

        send_byte(8'h41, "A");
        send_byte(8'h42, "B");
        chk("AB.cursor_x", cursor_x, 2);

        send_byte(8'h1F, "esc1");
        send_byte(8'h58, "esc1.row");
        send_byte(8'h67, "esc1.col");
        attr = 24'h123456;
        send_byte(8'h5A, "Z.wrap");
        chk("Z.cursor_y", cursor_y, 0);

        send_byte(8'h08, "bs.x0");
        send_byte(8'h1F, "esc2");
        send_byte(8'h58, "esc2.row");
        send_byte(8'h45, "esc2.col");
        send_byte(8'h0D, "cr");
        send_byte(8'h0A, "lf.wrap");
        send_byte(8'h08, "bs.x0b");

        send_byte(8'h1F, "esc3");
        send_byte(8'h7F, "esc3.row");
        send_byte(8'h7F, "esc3.col");
        send_byte(8'h1F, "esc4");
        send_byte(8'h30, "esc4.row");
        send_byte(8'h30, "esc4.col");
        send_byte(8'h1F, "esc5");
        send_byte(8'h0A, "esc5.row_ctl");
        send_byte(8'h0D, "esc5.col_ctl");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            attr = 24'($urandom);
            if (r < 5)       b = 8'($urandom_range(32, 255));
            else if (r == 5) b = 8'h1F;
            else if (r == 6) begin
                case ($urandom_range(0, 5))
                    0: b = 8'h08; 1: b = 8'h0A; 2: b = 8'h0D;
                    3: b = 8'h0C; 4: b = 8'h1B; default: b = 8'h00;
                endcase
            end else if (r == 7) b = 8'($urandom_range(8'h38, 8'h80));
            else b = 8'($urandom);
`ifdef TEXT_STREAM_WRITER_CLEAR_EN
            if (b == 8'h0C && mode == 0) b = 8'h0D;
`endif
            if ($urandom_range(0, 4) == 0) idle_cycle();
            send_byte(b, $sformatf("rnd%0d", i));
        end
        send_byte(8'h0D, "sync1");
        send_byte(8'h0D, "sync2");

`ifdef TEXT_STREAM_WRITER_CLEAR_EN
        send_byte(8'h1F, "pre.esc");
        send_byte(8'h48, "pre.row");
        send_byte(8'h4A, "pre.col");
        clear_sweep(COLS * ROWS, 8'h51);
        @(posedge clk);
        #1;
        ex = 0; ey = 0; mode = 0; exp_wr = 1'b0;
        chk("clr.end.write", write, 0);
        chk("clr.end.in_ready", in_ready, 1);
        chk("clr.end.busy", busy, 0);
        chk("clr.end.cursor_x", cursor_x, 0);
        chk("clr.end.cursor_y", cursor_y, 0);
        send_byte(8'h51, "Q.after_clear");

        send_byte(8'h41, "pre2");
        clear_sweep(300, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ex = 0; ey = 0; mode = 0; exp_wr = 1'b0;
        check_outputs("clr.reset");
        send_byte(8'h43, "C.after_reset");
`else
        send_byte(8'h33, "pre.ff");
        send_byte(8'h0C, "ff.ignored");
        idle_cycle();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
